instr_exec_unit: RTL and testbench
==================================

Name: instr_exec_unit

Overview:
- Execute stage directly downstream of instr_register.
- On start, walks read_pointer over a contiguous range of register entries and samples the returned instruction_word. It computes a signed result per entry and presents it on a valid/ready result port.
- Drives the register's read_pointer; the register's instruction_word is its only data input.
- Types come from instr_register_pkg (opcode_t, operand_t, address_t, instruction_t).

Parameters:
- ADDR_W, 5, width of read_pointer and first_addr; 2**ADDR_W register entries.
- OP_W, 32, operand width; operands are signed two's complement.
- RES_W, 64, result width (2*OP_W); holds a full signed product.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; accepted only in IDLE.
- first_addr  input  ADDR_W  first register entry to execute; sampled with start.
- num_instr  input  ADDR_W+1  entry count, 0..2**ADDR_W; sampled with start.
- read_pointer  output  ADDR_W  address driven to instr_register; registered.
- instruction_word  input  4+2*OP_W  {opc[3:0], op_a, op_b}, combinational read data at read_pointer.
- res_valid  output  1  result presented.
- res_ready  input  1  consumer accepts result.
- result  output  RES_W  signed result.
- result_addr  output  ADDR_W  register entry that produced result.
- div_err  output  1  qualifies result: DIV/MOD by zero, or illegal opcode.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset (async assert, sync release): state=IDLE, read_pointer=0, result=0, result_addr=0, res_valid=0, div_err=0, busy=0, done=0, count=0. Assertion mid-sequence aborts immediately; no further results are produced.
- FSM states: IDLE, FETCH, EXEC, OUT, DONE.
- IDLE:
  - start=1 with num_instr>0: read_pointer<=first_addr, count<=num_instr, go to FETCH.
  - start=1 with num_instr=0: go to DONE.
  - start in any other state is ignored.
- FETCH: instr_q<=instruction_word, go to EXEC. This is one cycle; read data is taken from the current read_pointer.
- EXEC: computes result from instr_q, sets result_addr<=read_pointer, sets div_err, goes to OUT.
- Arithmetic: operands are sign-extended to RES_W.
  - ZERO(0): 0.
  - PASSA(1): a.
  - PASSB(2): b.
  - ADD(3): a+b.
  - SUB(4): a-b.
  - MULT(5): a*b, full 64-bit.
  - DIV(6): a/b, truncation toward zero.
  - MOD(7): a%b, sign follows a.
  - b=0 for DIV/MOD: result=0, div_err=1.
  - Opcodes 8..15: result=0, div_err=1.
- OUT:
  - res_valid=1; result, result_addr and div_err are held stable until res_ready=1.
  - Handshake: a transfer occurs on a rising edge with res_valid&res_ready. Once asserted, res_valid does not drop without a transfer.
  - On transfer: res_valid<=0 and count<=count-1.
  - If count was 1, go to DONE. Otherwise read_pointer<=read_pointer+1 (wraps 2**ADDR_W-1 -> 0) and go to FETCH.
- DONE: done=1 for exactly one cycle, busy stays 1, then IDLE.
- Throughput: with res_ready tied high, 3 cycles per instruction. First res_valid appears 3 cycles after the start edge.
- busy is combinationally (state!=IDLE) but derived only from registered state.
- num_instr=2**ADDR_W executes every entry exactly once, ending at first_addr-1 (mod depth).

Test Plan:
- Reset mid-sequence: start first_addr=0, num_instr=4; assert reset_n=0 while in EXEC of entry 1 -> all outputs return to reset values immediately. After release, no res_valid without a new start.
- Basic ADD/SUB: entries 0..1 = {ADD,7,-3},{SUB,5,9}; start first_addr=0, num_instr=2, res_ready=1 -> results 4 (addr 0) then -4 (addr 1), div_err=0. done pulses once, 7 cycles after start.
- MULT/DIV/MOD signs: {MULT,-65536,65536},{DIV,-7,2},{MOD,-7,2} -> -4294967296, -3, -1.
- Divide by zero and illegal opcode: {DIV,10,0},{opcode 12,1,1} -> result 0, div_err=1 for both. Subsequent {PASSA,9,0} -> 9, div_err=0.
- Wrap and backpressure: first_addr=30, num_instr=4, res_ready toggling 1-of-3 cycles -> result_addr 30,31,0,1 in order. Each result is held stable while res_valid=1 and res_ready=0; no result is duplicated or dropped.
- Zero count and ignored start: num_instr=0 -> done pulse after 1 cycle, no res_valid. start pulsed while busy -> ignored, sequence unchanged.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared instruction register types.
// Opcode encoding and the {opc, op_a, op_b} word layout.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

endpackage

// File: rtl/instr_exec_unit_if.sv
// Result port of the execute stage.
// valid/ready handshake carrying result, source entry and error flag.
interface instr_exec_unit_if #(
    parameter int ADDR_W = 5,
    parameter int RES_W  = 64
);
    logic                     res_valid;
    logic                     res_ready;
    logic signed [RES_W-1:0]  result;
    logic [ADDR_W-1:0]        result_addr;
    logic                     div_err;

    modport master (
        output res_valid,
        output result,
        output result_addr,
        output div_err,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  result,
        input  result_addr,
        input  div_err,
        output res_ready
    );
endinterface

// File: rtl/instr_exec_unit.sv
// Execute stage behind instr_register: walks a range of entries,
// computes a signed result per entry and hands it out via valid/ready.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32,
    parameter int RES_W  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     first_addr,
    input  logic [ADDR_W:0]       num_instr,
    output logic [ADDR_W-1:0]     read_pointer,
    input  logic [4+2*OP_W-1:0]   instruction_word,
    instr_exec_unit_if.master     res,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = 4 + 2*OP_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [ADDR_W:0]         count;
    logic [IW-1:0]           instr_q;

    opcode_t                 opc;
    logic signed [OP_W-1:0]  op_a;
    logic signed [OP_W-1:0]  op_b;
    logic signed [RES_W-1:0] a_x;
    logic signed [RES_W-1:0] b_x;
    logic signed [RES_W-1:0] calc;
    logic                    err;

    assign busy = (state != S_IDLE);

    always_comb begin
        opc  = opcode_t'(instr_q[IW-1 -: 4]);
        op_a = instr_q[2*OP_W-1 -: OP_W];
        op_b = instr_q[OP_W-1:0];
        a_x  = {{(RES_W-OP_W){op_a[OP_W-1]}}, op_a};
        b_x  = {{(RES_W-OP_W){op_b[OP_W-1]}}, op_b};
        calc = '0;
        err  = 1'b0;
        case (opc)
            ZERO:  calc = '0;
            PASSA: calc = a_x;
            PASSB: calc = b_x;
            ADD:   calc = a_x + b_x;
            SUB:   calc = a_x - b_x;
            MULT:  calc = a_x * b_x;
            DIV: begin
                if (b_x == '0) err  = 1'b1;
                else           calc = a_x / b_x;
            end
            MOD: begin
                if (b_x == '0) err  = 1'b1;
                else           calc = a_x % b_x;
            end
            default: err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            read_pointer    <= '0;
            count           <= '0;
            instr_q         <= '0;
            res.result      <= '0;
            res.result_addr <= '0;
            res.res_valid   <= 1'b0;
            res.div_err     <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (num_instr != '0) begin
                            read_pointer <= first_addr;
                            count        <= num_instr;
                            state        <= S_FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    instr_q <= instruction_word;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    res.result      <= calc;
                    res.result_addr <= read_pointer;
                    res.div_err     <= err;
                    res.res_valid   <= 1'b1;
                    state           <= S_OUT;
                end
                S_OUT: begin
                    if (res.res_ready) begin
                        res.res_valid <= 1'b0;
                        count         <= count - (ADDR_W+1)'(1);
                        if (count == (ADDR_W+1)'(1)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            read_pointer <= read_pointer + ADDR_W'(1);
                            state        <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Scoreboard bench for instr_exec_unit: directed entries, backpressure,
// wrap, zero count, ignored start and mid-sequence reset.
module tb_instr_exec_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [4:0]  first_addr;
    logic [5:0]  num_instr;
    logic [4:0]  read_pointer;
    logic [67:0] instruction_word;
    logic        busy;
    logic        done;

    instr_exec_unit_if res_if ();

    instr_exec_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .num_instr        (num_instr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res              (res_if),
        .busy             (busy),
        .done             (done)
    );

    logic [67:0] mem [0:31];
    assign instruction_word = mem[read_pointer];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [67:0] mk(input logic [3:0] o,
                                       input int a, input int b);
        return {o, a[31:0], b[31:0]};
    endfunction

    function automatic void push(input logic [4:0] a,
                                 input longint r, input bit e);
        exp_t x;
        x.addr = a;
        x.res  = r;
        x.err  = e;
        sb.push_back(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input logic [4:0] fa, input logic [5:0] n,
                           input bit bp, input bit poke,
                           input int exp_done, input int exp_first);
        int          cyc;
        int          dones;
        int          done_at;
        int          first_v;
        bit          held;
        logic [63:0] h_res;
        logic [4:0]  h_addr;
        logic        h_err;
        exp_t        e;
        dones   = 0;
        done_at = -1;
        first_v = -1;
        held    = 1'b0;
        h_res   = '0;
        h_addr  = '0;
        h_err   = 1'b0;
        first_addr = fa;
        num_instr  = n;
        start      = 1'b1;
        res_if.res_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 300) begin
            if (done) begin
                dones++;
                done_at = cyc;
            end
            if (poke && cyc == 4) begin
                start      = 1'b1;
                first_addr = 5'd9;
                num_instr  = 6'd3;
            end else begin
                start = 1'b0;
            end
            res_if.res_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (res_if.res_valid) begin
                if (first_v < 0) first_v = cyc;
                if (held) begin
                    check("hold_result", res_if.result, h_res);
                    check("hold_addr", res_if.result_addr, h_addr);
                    check("hold_err", res_if.div_err, h_err);
                end
                if (res_if.res_ready) begin
                    check("result_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("result", res_if.result, e.res);
                        check("result_addr", res_if.result_addr, e.addr);
                        check("div_err", res_if.div_err, e.err);
                    end
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    h_res  = res_if.result;
                    h_addr = res_if.result_addr;
                    h_err  = res_if.div_err;
                end
            end
            if (!busy) break;
            tick();
            cyc++;
        end
        start = 1'b0;
        check("busy_end", busy, 0);
        check("done_pulses", dones, 1);
        if (exp_done >= 0) check("done_cycle", done_at, exp_done);
        check("first_valid_cycle", first_v, exp_first);
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    int nv;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset_n          = 1'b0;
        start            = 1'b0;
        first_addr       = '0;
        num_instr        = '0;
        res_if.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ptr", read_pointer, 0);
        check("rst_valid", res_if.res_valid, 0);
        check("rst_result", res_if.result, 0);
        check("rst_addr", res_if.result_addr, 0);
        check("rst_err", res_if.div_err, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        tick();

        mem[0] = mk(4'd3, 7, -3);
        mem[1] = mk(4'd4, 5, 9);
        mem[2] = mk(4'd5, -65536, 65536);
        mem[3] = mk(4'd6, -7, 2);
        mem[4] = mk(4'd7, -7, 2);
        mem[5] = mk(4'd6, 10, 0);
        mem[6] = mk(4'd12, 1, 1);
        mem[7] = mk(4'd1, 9, 0);
        mem[30] = mk(4'd3, 100, 23);
        mem[31] = mk(4'd2, 0, -8);

        // abort during EXEC of entry 1
        first_addr       = 5'd0;
        num_instr        = 6'd4;
        start            = 1'b1;
        res_if.res_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_pre_valid", res_if.res_valid, 1);
        check("abort_pre_result", res_if.result, 4);
        tick();
        tick();
        check("abort_pre_ptr", read_pointer, 1);
        reset_n = 1'b0;
        #1;
        check("abort_ptr", read_pointer, 0);
        check("abort_valid", res_if.res_valid, 0);
        check("abort_result", res_if.result, 0);
        check("abort_addr", res_if.result_addr, 0);
        check("abort_err", res_if.div_err, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        reset_n = 1'b1;
        nv = 0;
        repeat (12) begin
            tick();
            if (res_if.res_valid || busy || done) nv++;
        end
        check("abort_stays_idle", nv, 0);

        push(5'd0, 4, 1'b0);
        push(5'd1, -4, 1'b0);
        run_seq(5'd0, 6'd2, 1'b0, 1'b0, 7, 3);

        push(5'd2, -64'sd4294967296, 1'b0);
        push(5'd3, -3, 1'b0);
        push(5'd4, -1, 1'b0);
        run_seq(5'd2, 6'd3, 1'b0, 1'b0, 10, 3);

        push(5'd5, 0, 1'b1);
        push(5'd6, 0, 1'b1);
        push(5'd7, 9, 1'b0);
        run_seq(5'd5, 6'd3, 1'b0, 1'b1, 10, 3);

        push(5'd30, 123, 1'b0);
        push(5'd31, -8, 1'b0);
        push(5'd0, 4, 1'b0);
        push(5'd1, -4, 1'b0);
        run_seq(5'd30, 6'd4, 1'b1, 1'b0, -1, 3);

        run_seq(5'd3, 6'd0, 1'b0, 1'b0, 1, -1);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
